// File: rtl/bioz_siggen_pkg.sv
// Shared types and derivation helpers for the BioZ excitation generator.
// phase_to_onehot gives the bit index that is set in the one-hot DAC code for a phase.
package bioz_siggen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int calc_q(input int n_log2);
      return 1 << (n_log2 - 2);
   endfunction

   function automatic int calc_pw(input int n_log2);
      return (1 << (n_log2 - 1)) + 1;
   endfunction

   function automatic int clamp_k(input int sel, input int n_log2);
      return (sel > n_log2 - 2) ? (n_log2 - 2) : sel;
   endfunction

   // Half-sine mapping: rising/falling positive half, then the negative half on bits Q+1..2Q
   function automatic int phase_to_onehot(input int n_log2, input int p);
      int q;
      q = calc_q(n_log2);
      if (p <= q)          return p;
      else if (p <= 2 * q) return 2 * q - p;
      else if (p <= 3 * q) return p - q;
      else                 return 5 * q - p;
   endfunction

endpackage

// File: rtl/bioz_siggen_phase_decode.sv
// Combinational phase decode: one-hot DAC code, excitation clock and quadrant I/Q references.
// With run low every output takes its idle value.
module bioz_siggen_phase_decode
   import bioz_siggen_pkg::*;
#(
   parameter int N_LOG2 = 5,
   parameter int P_W    = calc_pw(N_LOG2)
) (
   input  logic [N_LOG2-1:0] p,
   input  logic [N_LOG2-1:0] q,
   input  logic              run,
   output logic [P_W-1:0]    p_code,
   output logic              clk_bioz,
   output logic              i_pos,
   output logic              i_neg,
   output logic              q_pos,
   output logic              q_neg
);

   always_comb begin
      p_code   = P_W'(1);
      clk_bioz = 1'b0;
      i_pos    = 1'b0;
      i_neg    = 1'b0;
      q_pos    = 1'b0;
      q_neg    = 1'b0;
      if (run) begin
         p_code   = P_W'(1) << phase_to_onehot(N_LOG2, int'(p));
         clk_bioz = ~p[N_LOG2-1];
         i_pos    = ~q[N_LOG2-1] & ~q[N_LOG2-2];
         i_neg    =  q[N_LOG2-1] & ~q[N_LOG2-2];
         q_pos    = ~q[N_LOG2-1] &  q[N_LOG2-2];
         q_neg    =  q[N_LOG2-1] &  q[N_LOG2-2];
      end
   end

endmodule

// File: rtl/bioz_siggen_dacctrl_param.sv
// BioZ excitation generator top: enable FSM, phase accumulator, period-boundary shadow
// registers for step size and I/Q offset, period counter and the registered outputs.
module bioz_siggen_dacctrl_param
   import bioz_siggen_pkg::*;
#(
   parameter int N_LOG2 = 5,
   parameter int P_W    = calc_pw(N_LOG2),
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Resetn,
   input  logic              Enable,
   input  logic [SEL_W-1:0]  StepSel,
   input  logic [N_LOG2-1:0] PhaseOfs,
   output logic [P_W-1:0]    P,
   output logic              clk_bioz_P,
   output logic              clk_bioz_N,
   output logic              IP,
   output logic              IN,
   output logic              QP,
   output logic              QN,
   output logic              clk_merged_IF_P,
   output logic              clk_merged_IF_N,
   output logic              Busy,
   output logic              PeriodDone,
   output logic [CNT_W-1:0]  PeriodCnt
);

   state_t              state, state_nxt;
   logic [N_LOG2-1:0]   p, p_nxt;
   logic [SEL_W-1:0]    k_act, k_in;
   logic [N_LOG2-1:0]   ofs;
   logic [N_LOG2-1:0]   stride;
   logic [N_LOG2:0]     sum;
   logic                wrap, run, load_cfg;

   logic [P_W-1:0]      dec_p;
   logic                dec_clk, dec_ip, dec_in, dec_qp, dec_qn, merged_nxt;

   assign run    = (state != ST_IDLE);
   assign k_in   = SEL_W'(clamp_k(int'(StepSel), N_LOG2));
   assign stride = N_LOG2'(1) << k_act;

   always_comb begin
      sum      = {1'b0, p} + {1'b0, stride};
      wrap     = run & sum[N_LOG2];
      load_cfg = ~run | wrap;
      p_nxt    = (run && !wrap) ? sum[N_LOG2-1:0] : '0;
   end

   // Dropping Enable on the wrap cycle ends the period there, so it goes straight to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (Enable) state_nxt = ST_RUN;
         ST_RUN:   if (!Enable) state_nxt = wrap ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: if (Enable) state_nxt = ST_RUN;
                   else if (wrap) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   bioz_siggen_phase_decode #(
      .N_LOG2 (N_LOG2),
      .P_W    (P_W)
   ) u_decode (
      .p        (p),
      .q        (p + ofs),
      .run      (run),
      .p_code   (dec_p),
      .clk_bioz (dec_clk),
      .i_pos    (dec_ip),
      .i_neg    (dec_in),
      .q_pos    (dec_qp),
      .q_neg    (dec_qn)
   );

   assign merged_nxt = run & ~((dec_ip | dec_qp) ^ dec_clk);

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state     <= ST_IDLE;
         p         <= '0;
         k_act     <= '0;
         ofs       <= '0;
         PeriodCnt <= '0;
      end else begin
         state <= state_nxt;
         p     <= p_nxt;
         if (load_cfg) begin
            k_act <= k_in;
            ofs   <= PhaseOfs;
         end
         if (!run)      PeriodCnt <= '0;
         else if (wrap) PeriodCnt <= PeriodCnt + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         P               <= P_W'(1);
         clk_bioz_P      <= 1'b0;
         IP              <= 1'b0;
         IN              <= 1'b0;
         QP              <= 1'b0;
         QN              <= 1'b0;
         clk_merged_IF_P <= 1'b0;
         Busy            <= 1'b0;
         PeriodDone      <= 1'b0;
      end else begin
         P               <= dec_p;
         clk_bioz_P      <= dec_clk;
         IP              <= dec_ip;
         IN              <= dec_in;
         QP              <= dec_qp;
         QN              <= dec_qn;
         clk_merged_IF_P <= merged_nxt;
         Busy            <= run;
         PeriodDone      <= wrap;
      end
   end

   assign clk_bioz_N      = ~clk_bioz_P;
   assign clk_merged_IF_N = ~clk_merged_IF_P;

endmodule

// File: tb/tb_bioz_siggen_dacctrl_param.sv
// Bench for bioz_siggen_dacctrl_param: directed scenarios plus random traffic, all
// checked cycle by cycle against a period-level behavioural model.
module tb_bioz_siggen_dacctrl_param;

   localparam int N_LOG2 = 5;
   localparam int NN     = 1 << N_LOG2;
   localparam int QQ     = NN / 4;
   localparam int P_W    = 17;

   logic              Clk;
   logic              Resetn;
   logic              Enable;
   logic [1:0]        StepSel;
   logic [4:0]        PhaseOfs;
   logic [P_W-1:0]    P;
   logic              clk_bioz_P, clk_bioz_N;
   logic              IP, IN, QP, QN;
   logic              clk_merged_IF_P, clk_merged_IF_N;
   logic              Busy, PeriodDone;
   logic [15:0]       PeriodCnt;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   bit m_busy  = 0;
   int m_phase = 0;
   int m_step  = 1;
   int m_ofs   = 0;
   int m_cnt   = 0;

   logic [P_W-1:0] exp_q[$];

   bioz_siggen_dacctrl_param #(.N_LOG2(N_LOG2), .SEL_W(2), .CNT_W(16)) dut (
      .Clk             (Clk),
      .Resetn          (Resetn),
      .Enable          (Enable),
      .StepSel         (StepSel),
      .PhaseOfs        (PhaseOfs),
      .P               (P),
      .clk_bioz_P      (clk_bioz_P),
      .clk_bioz_N      (clk_bioz_N),
      .IP              (IP),
      .IN              (IN),
      .QP              (QP),
      .QN              (QN),
      .clk_merged_IF_P (clk_merged_IF_P),
      .clk_merged_IF_N (clk_merged_IF_N),
      .Busy            (Busy),
      .PeriodDone      (PeriodDone),
      .PeriodCnt       (PeriodCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_phase = 0;
      m_cnt   = 0;
   endtask

   // Idle-value check, usable at any time (including right after an async reset)
   task automatic chk_idle(input string tag);
      chk({tag, "_P"}, 32'(P), 32'd1);
      chk({tag, "_clk"}, {30'd0, clk_bioz_P, clk_bioz_N}, 32'b01);
      chk({tag, "_iq"}, {28'd0, IP, IN, QP, QN}, 32'd0);
      chk({tag, "_mrg"}, {30'd0, clk_merged_IF_P, clk_merged_IF_N}, 32'b01);
      chk({tag, "_st"}, {30'd0, Busy, PeriodDone}, 32'd0);
      chk({tag, "_cnt"}, 32'(PeriodCnt), 32'd0);
   endtask

   // DAC bit index from the half-sine shape: positive lobe on 0..Q, negative lobe on Q+1..2Q
   function automatic int exp_bit(input int ph);
      int j;
      if (ph <= 2 * QQ) return (ph < 2 * QQ - ph) ? ph : 2 * QQ - ph;
      j = ph - 2 * QQ;
      return QQ + ((j < 2 * QQ - j) ? j : 2 * QQ - j);
   endfunction

   // One clock: drive inputs, advance the model at the edge, check outputs at the falling edge
   task automatic tick(input logic en, input logic [1:0] sel, input logic [4:0] po);
      bit pre_busy, wrapped;
      int pre_ph, pre_ofs, quad, nxt, kk;
      logic e_clk, e_ip, e_in, e_qp, e_qn, e_mrg;
      logic [P_W-1:0] ep;
      Enable   = en;
      StepSel  = sel;
      PhaseOfs = po;
      @(posedge Clk);
      pre_busy = m_busy;
      pre_ph   = m_phase;
      pre_ofs  = m_ofs;
      wrapped  = 0;
      kk = (int'(sel) > N_LOG2 - 2) ? N_LOG2 - 2 : int'(sel);
      if (!Resetn) begin
         model_reset();
      end else if (!m_busy) begin
         m_phase = 0;
         m_step  = 1 << kk;
         m_ofs   = int'(po);
         m_cnt   = 0;
         m_busy  = en;
      end else begin
         nxt = m_phase + m_step;
         wrapped = (nxt >= NN);
         if (wrapped) begin
            m_phase = 0;
            m_cnt   = (m_cnt + 1) % 65536;
            m_step  = 1 << kk;
            m_ofs   = int'(po);
         end else begin
            m_phase = nxt;
         end
         m_busy = en || !wrapped;
      end
      if (pre_busy) begin
         ep    = P_W'(1) << exp_bit(pre_ph);
         quad  = ((pre_ph + pre_ofs) % NN) / QQ;
         e_clk = (pre_ph < NN / 2);
         e_ip  = (quad == 0);
         e_qp  = (quad == 1);
         e_in  = (quad == 2);
         e_qn  = (quad == 3);
         e_mrg = ((e_ip | e_qp) == e_clk);
      end else begin
         ep = P_W'(1);
         {e_clk, e_ip, e_in, e_qp, e_qn, e_mrg} = '0;
      end
      exp_q.push_back(ep);
      @(negedge Clk);
      chk("P", 32'(P), 32'(exp_q.pop_front()));
      chk("clk_bioz", {30'd0, clk_bioz_P, clk_bioz_N}, {30'd0, e_clk, ~e_clk});
      chk("iq", {28'd0, IP, IN, QP, QN}, {28'd0, e_ip, e_in, e_qp, e_qn});
      chk("merged", {30'd0, clk_merged_IF_P, clk_merged_IF_N}, {30'd0, e_mrg, ~e_mrg});
      chk("busy", 32'(Busy), 32'(pre_busy));
      chk("done", 32'(PeriodDone), 32'(wrapped));
      chk("cnt", 32'(PeriodCnt), 32'(m_cnt));
   endtask

   // Assert reset between edges; outputs must go idle without waiting for a clock
   task automatic async_reset(input logic en);
      @(posedge Clk);
      #2 Resetn = 1'b0;
      #1 chk_idle("async_rst");
      model_reset();
      exp_q.delete();
      @(negedge Clk);
      tick(en, 2'd0, 5'd0);
      Resetn = 1'b1;
   endtask

   initial begin
      logic en_r;
      Resetn   = 1'b0;
      Enable   = 1'b0;
      StepSel  = 2'd0;
      PhaseOfs = 5'd0;
      repeat (2) @(negedge Clk);
      chk_idle("reset");
      Resetn = 1'b1;

      // full 32-step period, several periods
      repeat (100) tick(1'b1, 2'd0, 5'd0);
      // 16-step periods, selected mid-period
      repeat (70) tick(1'b1, 2'd1, 5'd0);
      repeat (37) tick(1'b1, 2'd0, 5'd0);
      repeat (40) tick(1'b1, 2'd1, 5'd0);
      // drain to idle, then re-raise during drain
      repeat (20) tick(1'b1, 2'd0, 5'd0);
      repeat (25) tick(1'b0, 2'd0, 5'd0);
      repeat (20) tick(1'b1, 2'd0, 5'd0);
      repeat (5)  tick(1'b0, 2'd0, 5'd0);
      repeat (40) tick(1'b1, 2'd0, 5'd0);
      // quadrant offset
      repeat (70) tick(1'b1, 2'd0, 5'd8);
      // coarsest steps (clamped select)
      repeat (20) tick(1'b1, 2'd3, 5'd3);
      // async reset mid-period, restart from bit0
      repeat (13) tick(1'b1, 2'd0, 5'd0);
      async_reset(1'b1);
      repeat (40) tick(1'b1, 2'd0, 5'd0);

      en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) en_r = ~en_r;
         if ($urandom_range(0, 599) == 0) async_reset(en_r);
         else tick(en_r, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
